// File: rtl/im_arb_pkg.sv
// -----------------------------------------------------------------------------
// im_arb_pkg
// Shared definitions for the instruction-memory arbiter: arbiter state
// encoding, memory address/word widths and the width of the debug
// bounded-wait counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package im_arb_pkg;

    localparam int ADDR_W = 16;   // instruction memory word address width
    localparam int WORD_W = 32;   // instruction memory word width
    localparam int WAIT_W = 4;    // debug wait counter width (MAX_WAIT <= 15)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_F_BUSY = 2'd1,
        ST_D_BUSY = 2'd2
    } state_t;

endpackage : im_arb_pkg

// File: rtl/im_arb_wait_cnt.sv
// -----------------------------------------------------------------------------
// im_arb_wait_cnt
// Saturating counter tracking how many edges a pending debug request has
// been passed over. Clear has priority over increment; the count stops at
// MAX_WAIT and `sat` flags that the debug port must win the next arbitration.
//
// Ports:
//   clk    in  system clock
//   rst_f  in  asynchronous active-low reset
//   inc    in  count one more passed-over edge
//   clr    in  return the count to zero
//   sat    out count has reached MAX_WAIT
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module im_arb_wait_cnt
    import im_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_f,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [WAIT_W-1:0] L_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != L_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign sat = (r_count == L_MAX);

endmodule : im_arb_wait_cnt

// File: rtl/im_arbiter.sv
// -----------------------------------------------------------------------------
// im_arbiter
// Shares the single instruction memory between the fetch unit and the
// debug/program-loader port. One one-word transaction at a time: the grant
// edge latches the winner's address, the completion edge registers read data
// and raises a one-cycle ack. Fetch has fixed priority; a bounded-wait counter
// forces a pending debug request through once it has been passed over
// MAX_WAIT times.
//
// Configuration macro: IM_ARB_WRITE_EN
//   defined   - debug writes drive mem_we / mem_wdata for one D_BUSY cycle
//   undefined - mem_we and mem_wdata stay 0, debug writes complete as reads
//
// Ports:
//   clk, rst_f                     clock, asynchronous active-low reset
//   f_req, f_addr                  fetch request / word address
//   f_ack, f_rdata                 fetch completion pulse / instruction
//   d_req, d_addr, d_we, d_wdata   debug request / address / write / data
//   d_ack, d_rdata                 debug completion pulse / read data
//   mem_addr, mem_we, mem_wdata    instruction memory address / write
//   mem_rdata                      instruction memory read data (comb.)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module im_arbiter
    import im_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_f,
    // fetch port
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [WORD_W-1:0] f_rdata,
    // debug port
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] d_rdata,
    // instruction memory
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata
);

    state_t            r_state;
    logic              r_f_ack;
    logic              r_d_ack;
    logic [WORD_W-1:0] r_f_rdata;
    logic [WORD_W-1:0] r_d_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [WORD_W-1:0] r_mem_wdata;

    logic w_f_ok;
    logic w_d_ok;
    logic w_idle;
    logic w_sat;
    logic w_grant_f;
    logic w_grant_d;
    logic w_d_write;

`ifdef IM_ARB_WRITE_EN
    assign w_d_write = d_we;
`else
    // Write requests are serviced as reads; the write inputs stay on the
    // port list for a uniform interface but drive nothing.
    logic w_unused_write;
    assign w_d_write      = 1'b0;
    assign w_unused_write = ^{d_we, d_wdata};
`endif

    // A port whose ack is high this cycle sits out arbitration, giving the
    // requester one cycle to drop or change its request.
    assign w_f_ok = f_req && !r_f_ack;
    assign w_d_ok = d_req && !r_d_ack;
    assign w_idle = (r_state == ST_IDLE);

    // Debug wins when forced by the wait counter, or when fetch is not asking.
    assign w_grant_d = w_idle && w_d_ok && (w_sat || !w_f_ok);
    assign w_grant_f = w_idle && w_f_ok && !(w_d_ok && w_sat);

    im_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_f (rst_f),
        .inc   (d_req && (r_state != ST_D_BUSY) && !w_grant_d),
        .clr   (!d_req || w_grant_d),
        .sat   (w_sat)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state     <= ST_IDLE;
            r_f_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_f_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            // Acks and the write strobe are single-cycle unless re-asserted.
            r_f_ack  <= 1'b0;
            r_d_ack  <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state    <= ST_D_BUSY;
                        r_mem_addr <= d_addr;
`ifdef IM_ARB_WRITE_EN
                        if (w_d_write) begin
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= d_wdata;
                        end
`endif
                    end else if (w_grant_f) begin
                        r_state    <= ST_F_BUSY;
                        r_mem_addr <= f_addr;
                    end
                end
                ST_F_BUSY: begin
                    r_f_rdata <= mem_rdata;
                    r_f_ack   <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                ST_D_BUSY: begin
                    // r_mem_we is high exactly while a write occupies D_BUSY.
                    if (!r_mem_we) begin
                        r_d_rdata <= mem_rdata;
                    end
                    r_d_ack <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign f_ack     = r_f_ack;
    assign d_ack     = r_d_ack;
    assign f_rdata   = r_f_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule : im_arbiter

// File: doc/im_arbiter.md
# im_arbiter

Two-port arbiter sharing the single SISC instruction memory between the processor fetch unit and a debug/program-loader port. It sits directly in front of the instruction memory and owns that memory's address and write signals. It grants one one-word transaction at a time and returns read data through a registered response with a one-cycle acknowledge pulse. Fetch has fixed priority, and a bounded-wait counter guarantees the debug port cannot be starved.

## Interface
- `MAX_WAIT`, default 4: cycles a pending debug request may be passed over before it is forced to win; legal range 1–15.
- `clk` in 1: system clock, all state on rising edge.
- `rst_f` in 1: reset, asynchronous, active-low.
- `f_req` in 1: fetch request, held until `f_ack`.
- `f_addr` in 16: fetch word address.
- `f_ack` out 1: one-cycle completion pulse.
- `f_rdata` out 32: fetched instruction, valid when `f_ack`=1, held until next fetch completion.
- `d_req` in 1: debug request, held until `d_ack`.
- `d_addr` in 16: debug word address.
- `d_we` in 1: debug write (1) or read (0).
- `d_wdata` in 32: debug write data.
- `d_ack` out 1: one-cycle completion pulse.
- `d_rdata` out 32: debug read data, valid when `d_ack`=1 for reads.
- `mem_addr` out 16: instruction memory address.
- `mem_rdata` in 32: instruction memory read data, combinational from `mem_addr`.
- `mem_we` out 1: instruction memory write strobe.
- `mem_wdata` out 32: instruction memory write data.

## Operation
- States: IDLE, F_BUSY, D_BUSY.
- IDLE arbitration at each rising edge:
  - If `d_req` and wait count = `MAX_WAIT`, go to D_BUSY.
  - Otherwise, if `f_req`, go to F_BUSY.
  - Otherwise, if `d_req`, go to D_BUSY.
  - Otherwise stay in IDLE.
- On entry to a BUSY state, `mem_addr` latches the winner's address. For a D_BUSY write, `mem_wdata` latches `d_wdata`.
- F_BUSY: at the next edge, `f_rdata` ← `mem_rdata` and `f_ack` ← 1; state returns to IDLE.
- D_BUSY, read: at the next edge, `d_rdata` ← `mem_rdata` and `d_ack` ← 1; state returns to IDLE.
- D_BUSY, write: `mem_we`=1 for the whole D_BUSY cycle (registered). At the next edge `d_ack` ← 1, `d_rdata` is unchanged, and state returns to IDLE.
- A port whose ack is high in the current IDLE cycle is ignored for arbitration that cycle. This gives the requester one cycle to drop or change its request.
- Wait count (4 bits):
  - +1 on each edge where `d_req`=1, the state is not D_BUSY, and D_BUSY is not being entered.
  - Saturates at `MAX_WAIT`.
  - Cleared on entry to D_BUSY and whenever `d_req`=0.
- `mem_addr` and `mem_wdata` hold their last values in IDLE. `mem_we` is 0 outside D_BUSY.
- Request inputs may change only in IDLE or in an ack cycle. Changing them during BUSY is a protocol violation and has no defined effect.

## Timing
- Reset values: state IDLE, `f_ack`=0, `d_ack`=0, `f_rdata`=0, `d_rdata`=0, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, wait count 0.
- Latency from a request seen in IDLE to its ack is 2 edges (grant, then completion). Peak throughput is one transaction per 2 cycles.
- Acks are exactly one cycle wide. At most one ack is high in any cycle.
- When `f_req` and `d_req` arrive together, fetch wins unless the wait count has saturated.
- Under continuous fetch traffic, debug is granted no later than the `MAX_WAIT`+1-th IDLE arbitration after `d_req` rises.
- Reset asserted mid-transaction forces all reset values immediately. The in-flight transaction is dropped with no ack and no write.
- Address 16'hFFFF is legal and has no wrap-around special case.

## Configuration
- `IM_ARB_WRITE_EN` defined: debug writes are performed as described above.
- `IM_ARB_WRITE_EN` undefined:
  - `mem_we` is tied to 0 and `mem_wdata` to 0.
  - A debug request with `d_we`=1 is treated as a read: `d_ack` is returned and `d_rdata` is loaded from `mem_rdata`.
  - The `d_we` and `d_wdata` ports remain present but are otherwise unused.

## Structure
- Shared package `im_arb_pkg` holds:
  - state encoding constants `ST_IDLE`=2'd0, `ST_F_BUSY`=2'd1, `ST_D_BUSY`=2'd2;
  - address width 16 and word width 32;
  - wait-counter width 4.
- One sub-module, `im_arb_wait_cnt`: a saturating counter with inputs `inc`, `clr` and a `sat` flag, parameterised by `MAX_WAIT`.

## Test plan
- Reset, then fetch `f_addr`=16'h0003 with memory word 3 = 32'h1234ABCD → `f_ack` pulses at edge 2 with `f_rdata`=32'h1234ABCD. `mem_we` stays 0 throughout.
- `f_req` and `d_req` raised together, `MAX_WAIT`=4 → fetch acks first. Debug is granted in the following IDLE cycle because fetch is ignored during its ack cycle.
- `f_req` held continuously with a new address after each ack, plus `d_req` held → debug granted by its 5th IDLE arbitration and the wait count clears.
- `IM_ARB_WRITE_EN` defined, debug write of 32'hDEADBEEF to address 16'h0010 → `mem_we`=1 for exactly one cycle with that address and data. A following debug read returns 32'hDEADBEEF.
- `IM_ARB_WRITE_EN` undefined, the same write → `mem_we` never asserts, `d_ack` pulses, and `d_rdata` holds the original word.
- `rst_f` dropped during F_BUSY → `f_ack` never pulses and all outputs read 0 immediately. After release, a new fetch completes normally.
